reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
Write-side controller that owns the register file's single write port (we/wa/wd).
- Merges two result sources:
  - the in-order pipeline writeback stage (primary): never stalls, always wins the port;
  - long-latency units such as mult/div (secondary): valid/ready handshake, results buffered in a small FIFO.
- Enforces write ordering by squashing stale queued results.
- Exports a pending-write mask the hazard unit uses to stall readers.

Parameters:
DEPTH, 4, secondary FIFO entries; power of 2, minimum 2
PTR_W, $clog2(DEPTH), FIFO pointer width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
reg_reset  in  1  asynchronous, active-low reset
pri_valid  in  1  primary result valid this cycle
pri_wa  in  5  primary destination register
pri_wd  in  32  primary data
sec_valid  in  1  secondary result offered
sec_ready  out  1  FIFO can accept; equals !full
sec_wa  in  5  secondary destination register
sec_wd  in  32  secondary data
rf_we  out  1  register file write enable (registered)
rf_wa  out  5  register file write address (registered)
rf_wd  out  32  register file write data (registered)
pend_mask  out  32  bit i set = a write to register i is queued or in the output stage
fifo_count  out  PTR_W+1  occupied FIFO entries

Behaviour:
- Reset (reg_reset=0, async):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - FIFO empty, all entry valid bits 0, pointers 0.
  - pend_mask=0, fifo_count=0, sec_ready=1.
- Acceptance:
  - Secondary handshake completes when sec_valid && sec_ready. Data is enqueued at that edge.
  - Pass-through is not allowed; ready depends only on !full.
- Register 0:
  - A primary write with pri_wa=0 produces rf_we=0 that cycle.
  - A secondary accept with sec_wa=0 is acknowledged but enqueued with valid=0.
- Output stage, updated every edge:
  - If pri_valid: rf_we=(pri_wa!=0), rf_wa=pri_wa, rf_wd=pri_wd. The FIFO does not pop.
  - Else if the FIFO is non-empty: pop the head; rf_we=head.valid, rf_wa/rf_wd from head.
  - Else: rf_we=0; rf_wa/rf_wd hold their previous values.
- Latency:
  - Primary: 1 cycle to rf_we.
  - Secondary into an empty FIFO with no primary traffic: accept at edge N, rf_we high after edge N+1.
- Squash (WAW ordering; the primary result is always younger):
  - On pri_valid with pri_wa=X (X!=0), clear valid of every queued entry with wa==X at the same edge.
  - A secondary entry accepted in that same cycle with sec_wa==X is enqueued with valid=0.
  - A popped invalid entry consumes its slot and produces rf_we=0.
- Simultaneous enqueue and pop on a full FIFO: the pop frees a slot, but sec_ready was 0 that cycle, so no accept occurs.
- Pointers are PTR_W+1 bits and wrap naturally. full = MSBs differ and low bits equal; empty = pointers equal.
- pend_mask (combinational) = OR over occupied valid entries of onehot(wa), OR onehot(rf_wa) when rf_we=1. Bit 0 is always 0.
- Reset asserted mid-operation discards all queued entries; no write is issued on the cycle reset deasserts.

Optional Feature:
WB_SQUASH_CNT_EN
- Defined: adds output squash_cnt [15:0], a saturating count (stops at 16'hFFFF) of entries invalidated by squash plus r0 secondary accepts. Reset value 0. An entry is counted once, when its valid bit falls or it is enqueued invalid.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package (cpu_pkg):
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32;
  - typedef wb_entry_t {valid, wa[4:0], wd[31:0]}.
- Sub-module wb_fifo:
  - Storage, pointers, full/empty/count.
  - Per-entry valid bits with a squash-by-address port.
- The top level holds output-stage muxing and pend_mask.

Test Plan:
- Primary only: pri_valid=1, wa=5, wd=32'hDEADBEEF at edge N -> rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF after edge N; pend_mask[5]=1 for that cycle only.
- Secondary fill:
  - stimulus: pri_valid held 1 (wa=1); push 4 secondary results to regs 8..11;
  - response: sec_ready falls after the 4th accept and fifo_count=4;
  - after pri_valid drops: writes to 8,9,10,11 in order on 4 consecutive cycles; sec_ready=1 after the first pop.
- Squash:
  - stimulus: queue sec wa=7 wd=1, then pri wa=7 wd=2 while that entry is still queued;
  - response: rf writes 7<=2 only; the queued entry pops with rf_we=0; with WB_SQUASH_CNT_EN, squash_cnt=1.
- Same-cycle collision: sec accept wa=3 and pri wa=3 in the same cycle -> only the primary write is issued; pend_mask[3] clears once the invalid entry drains.
- Register 0: pri wa=0 and sec wa=0 -> rf_we never asserts; pend_mask[0] stays 0.
- Reset mid-operation: 3 entries queued, reg_reset pulsed low between edges -> outputs are 0 immediately (asynchronously) and no writes follow reset release.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths, writeback entry type and one-hot helper
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
    } wb_entry_t;

    // One-hot register select; callers mask bit 0 where r0 must never appear
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - secondary result queue with per-entry valid bits and squash-by-address
module wb_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reg_reset,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    input  logic                squash_en,
    input  logic [REG_ADDR_W-1:0] squash_wa,
    output wb_entry_t           head,
    output logic                full,
    output logic                empty,
    output logic [PTR_W:0]      count,
    output logic [NUM_REGS-1:0] queued_mask,
    output logic [PTR_W:0]      squash_hits
);

    logic [PTR_W:0]          wr_ptr;
    logic [PTR_W:0]          rd_ptr;
    logic [PTR_W-1:0]        wr_idx;
    logic [PTR_W-1:0]        rd_idx;
    logic [DEPTH-1:0]        vld;
    logic [DEPTH-1:0]        occ;
    logic [DEPTH-1:0]        hit;
    logic                    push_ok;
    logic                    pop_ok;
    logic [REG_ADDR_W-1:0]   mem_wa [DEPTH];
    logic [DATA_W-1:0]       mem_wd [DEPTH];

    assign wr_idx  = wr_ptr[PTR_W-1:0];
    assign rd_idx  = rd_ptr[PTR_W-1:0];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = {vld[rd_idx], mem_wa[rd_idx], mem_wd[rd_idx]};

    // Occupancy per slot, squash matches, and the mask of registers still owed a write
    always_comb begin
        occ         = '0;
        hit         = '0;
        queued_mask = '0;
        squash_hits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ((PTR_W+1)'(PTR_W'(PTR_W'(i) - rd_idx)) < count);
            hit[i] = squash_en && occ[i] && vld[i] && (mem_wa[i] == squash_wa);
            if (occ[i] && vld[i]) begin
                queued_mask = queued_mask | reg_onehot(mem_wa[i]);
            end
            if (hit[i]) begin
                squash_hits = squash_hits + 1'b1;
            end
        end
        queued_mask[0] = 1'b0;
    end

    // Pointers and valid bits; a slot's valid is dropped when squashed or freed by a pop
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop_ok) begin
                vld[rd_idx] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                vld[wr_idx] <= push_entry.valid;
                wr_ptr      <= wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: an unoccupied slot is never observed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_wa[wr_idx] <= push_entry.wa;
            mem_wd[wr_idx] <= push_entry.wd;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - register-file write port arbiter; WB_SQUASH_CNT_EN adds squash_cnt
module reg_writeback_ctrl
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reg_reset,
    input  logic                  pri_valid,
    input  logic [REG_ADDR_W-1:0] pri_wa,
    input  logic [DATA_W-1:0]     pri_wd,
    input  logic                  sec_valid,
    output logic                  sec_ready,
    input  logic [REG_ADDR_W-1:0] sec_wa,
    input  logic [DATA_W-1:0]     sec_wd,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_wd,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic [PTR_W:0]        fifo_count
`ifdef WB_SQUASH_CNT_EN
    ,
    output logic [15:0]           squash_cnt
`endif
);

    logic                pri_live;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    wb_entry_t           push_entry;
    wb_entry_t           head;
    logic [NUM_REGS-1:0] queued_mask;
    logic [PTR_W:0]      squash_hits;

    // A primary write to r0 is a no-op and must not squash anything
    assign pri_live  = pri_valid && (pri_wa != '0);
    assign sec_ready = !full;
    assign push      = sec_valid && sec_ready;
    assign pop       = !pri_valid && !empty;

    // The primary result is younger, so a same-cycle secondary to the same register is dead on arrival
    assign push_entry = {(sec_wa != '0) && !(pri_live && (sec_wa == pri_wa)), sec_wa, sec_wd};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reg_reset   (reg_reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash_en   (pri_live),
        .squash_wa   (pri_wa),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (fifo_count),
        .queued_mask (queued_mask),
        .squash_hits (squash_hits)
    );

    // Output stage: primary wins, else drain one queued entry, else hold address/data idle
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (pri_valid) begin
            rf_we <= (pri_wa != '0);
            rf_wa <= pri_wa;
            rf_wd <= pri_wd;
        end else if (!empty) begin
            rf_we <= head.valid;
            rf_wa <= head.wa;
            rf_wd <= head.wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Registers with a write still in flight: valid queued entries plus the output stage
    always_comb begin
        pend_mask = queued_mask;
        if (rf_we) begin
            pend_mask = pend_mask | reg_onehot(rf_wa);
        end
        pend_mask[0] = 1'b0;
    end

`ifdef WB_SQUASH_CNT_EN
    logic [PTR_W+1:0] squash_inc;
    logic [16:0]      squash_sum;

    // Entries killed this edge: squashed queue slots plus any secondary enqueued already invalid
    always_comb begin
        squash_inc = {1'b0, squash_hits} + (PTR_W+2)'(push && !push_entry.valid);
        squash_sum = {1'b0, squash_cnt} + 17'(squash_inc);
    end

    // Saturating squash counter
    always_ff @(posedge clk or negedge reg_reset) begin
        if (!reg_reset) begin
            squash_cnt <= '0;
        end else begin
            squash_cnt <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - directed self-checking bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reg_reset;
    logic        pri_valid;
    logic [4:0]  pri_wa;
    logic [31:0] pri_wd;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_wa;
    logic [31:0] sec_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;
`ifdef WB_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    reg_writeback_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .reg_reset  (reg_reset),
        .pri_valid  (pri_valid),
        .pri_wa     (pri_wa),
        .pri_wd     (pri_wd),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_wa     (sec_wa),
        .sec_wd     (sec_wd),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
`ifdef WB_SQUASH_CNT_EN
        ,
        .squash_cnt (squash_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reg_reset = 1'b0;
        pri_valid = 1'b0; pri_wa = '0; pri_wd = '0;
        sec_valid = 1'b0; sec_wa = '0; sec_wd = '0;
        step(); step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_wa !== 5'd0) $display("FAIL reset_rf_wa got %0d want 0", rf_wa); else pass_cnt++;
        total_cnt++; if (rf_wd !== 32'd0) $display("FAIL reset_rf_wd got %h want 0", rf_wd); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL reset_pend got %h want 0", pend_mask); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (sec_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", sec_ready); else pass_cnt++;
`ifdef WB_SQUASH_CNT_EN
        total_cnt++; if (squash_cnt !== 16'd0) $display("FAIL reset_squash_cnt got %0d want 0", squash_cnt); else pass_cnt++;
`endif
        reg_reset = 1'b1;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL release_rf_we got %0b want 0", rf_we); else pass_cnt++;
    endtask

    task automatic test_primary();
        pri_valid = 1'b1; pri_wa = 5'd5; pri_wd = 32'hDEADBEEF;
        step();
        pri_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1) $display("FAIL pri_we got %0b want 1", rf_we); else pass_cnt++;
        total_cnt++; if (rf_wa !== 5'd5) $display("FAIL pri_wa got %0d want 5", rf_wa); else pass_cnt++;
        total_cnt++; if (rf_wd !== 32'hDEADBEEF) $display("FAIL pri_wd got %h want deadbeef", rf_wd); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'h0000_0020) $display("FAIL pri_pend got %h want 00000020", pend_mask); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL pri_idle_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_wa !== 5'd5) $display("FAIL pri_hold_wa got %0d want 5", rf_wa); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL pri_idle_pend got %h want 0", pend_mask); else pass_cnt++;
    endtask

    task automatic test_fill();
        pri_valid = 1'b1; pri_wa = 5'd1; pri_wd = 32'h100;
        sec_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sec_wa = 5'(8 + k); sec_wd = 32'h80 + 32'(k);
            total_cnt++; if (sec_ready !== 1'b1) $display("FAIL fill_ready_%0d got %0b want 1", k, sec_ready); else pass_cnt++;
            step();
            total_cnt++; if (fifo_count !== 3'(k + 1)) $display("FAIL fill_count_%0d got %0d want %0d", k, fifo_count, k + 1); else pass_cnt++;
        end
        total_cnt++; if (sec_ready !== 1'b0) $display("FAIL full_ready got %0b want 0", sec_ready); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'h0000_0F02) $display("FAIL full_pend got %h want 00000f02", pend_mask); else pass_cnt++;
        // Offer a fifth result while full during the first pop: must not be accepted
        pri_valid = 1'b0;
        sec_wa = 5'd20; sec_wd = 32'h99;
        for (int k = 0; k < 4; k++) begin
            step();
            sec_valid = 1'b0;
            total_cnt++; if (rf_we !== 1'b1) $display("FAIL drain_we_%0d got %0b want 1", k, rf_we); else pass_cnt++;
            total_cnt++; if (rf_wa !== 5'(8 + k)) $display("FAIL drain_wa_%0d got %0d want %0d", k, rf_wa, 8 + k); else pass_cnt++;
            total_cnt++; if (rf_wd !== 32'h80 + 32'(k)) $display("FAIL drain_wd_%0d got %h want %h", k, rf_wd, 32'h80 + 32'(k)); else pass_cnt++;
            total_cnt++; if (fifo_count !== 3'(3 - k)) $display("FAIL drain_count_%0d got %0d want %0d", k, fifo_count, 3 - k); else pass_cnt++;
            total_cnt++; if (sec_ready !== 1'b1) $display("FAIL drain_ready_%0d got %0b want 1", k, sec_ready); else pass_cnt++;
        end
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL drain_done_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL drain_done_pend got %h want 0", pend_mask); else pass_cnt++;
    endtask

    task automatic test_sec_latency();
        sec_valid = 1'b1; sec_wa = 5'd6; sec_wd = 32'h66;
        step();
        sec_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL lat_accept_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'h40) $display("FAIL lat_pend got %h want 00000040", pend_mask); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd6 || rf_wd !== 32'h66) $display("FAIL lat_write got we=%0b wa=%0d wd=%h want 1/6/66", rf_we, rf_wa, rf_wd); else pass_cnt++;
        step();
    endtask

    task automatic test_squash();
        sec_valid = 1'b1; sec_wa = 5'd7; sec_wd = 32'd1;
        pri_valid = 1'b1; pri_wa = 5'd2; pri_wd = 32'h22;
        step();
        sec_valid = 1'b0;
        total_cnt++; if (pend_mask !== 32'h84) $display("FAIL sq_pend_q got %h want 00000084", pend_mask); else pass_cnt++;
        pri_wa = 5'd7; pri_wd = 32'd2;
        step();
        pri_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'd2) $display("FAIL sq_pri got we=%0b wa=%0d wd=%h want 1/7/2", rf_we, rf_wa, rf_wd); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd1) $display("FAIL sq_count got %0d want 1", fifo_count); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'h80) $display("FAIL sq_pend got %h want 00000080", pend_mask); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL sq_pop_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL sq_pop_count got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL sq_pop_pend got %h want 0", pend_mask); else pass_cnt++;
`ifdef WB_SQUASH_CNT_EN
        total_cnt++; if (squash_cnt !== 16'd1) $display("FAIL sq_cnt got %0d want 1", squash_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_collision();
        sec_valid = 1'b1; sec_wa = 5'd3; sec_wd = 32'h33;
        pri_valid = 1'b1; pri_wa = 5'd3; pri_wd = 32'h44;
        step();
        sec_valid = 1'b0; pri_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h44) $display("FAIL col_pri got we=%0b wa=%0d wd=%h want 1/3/44", rf_we, rf_wa, rf_wd); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd1) $display("FAIL col_count got %0d want 1", fifo_count); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'h8) $display("FAIL col_pend got %h want 00000008", pend_mask); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL col_pop_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL col_pop_pend got %h want 0", pend_mask); else pass_cnt++;
`ifdef WB_SQUASH_CNT_EN
        total_cnt++; if (squash_cnt !== 16'd2) $display("FAIL col_cnt got %0d want 2", squash_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_r0();
        sec_valid = 1'b1; sec_wa = 5'd0; sec_wd = 32'h55;
        pri_valid = 1'b1; pri_wa = 5'd0; pri_wd = 32'h77;
        total_cnt++; if (sec_ready !== 1'b1) $display("FAIL r0_ready got %0b want 1", sec_ready); else pass_cnt++;
        step();
        sec_valid = 1'b0; pri_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL r0_pri_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd1) $display("FAIL r0_count got %0d want 1", fifo_count); else pass_cnt++;
        total_cnt++; if (pend_mask !== 32'd0) $display("FAIL r0_pend got %h want 0", pend_mask); else pass_cnt++;
        step();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL r0_pop_we got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL r0_pop_count got %0d want 0", fifo_count); else pass_cnt++;
`ifdef WB_SQUASH_CNT_EN
        total_cnt++; if (squash_cnt !== 16'd3) $display("FAIL r0_cnt got %0d want 3", squash_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        pri_valid = 1'b1; pri_wa = 5'd1; pri_wd = 32'hAB;
        sec_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sec_wa = 5'(12 + k); sec_wd = 32'hC0 + 32'(k);
            step();
        end
        sec_valid = 1'b0; pri_valid = 1'b0;
        total_cnt++; if (fifo_count !== 3'd3) $display("FAIL mid_count got %0d want 3", fifo_count); else pass_cnt++;
        #1 reg_reset = 1'b0;
        #1;
        total_cnt++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) $display("FAIL mid_async got we=%0b wa=%0d wd=%h want 0/0/0", rf_we, rf_wa, rf_wd); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0 || pend_mask !== 32'd0) $display("FAIL mid_async_q got count=%0d pend=%h want 0/0", fifo_count, pend_mask); else pass_cnt++;
        #1 reg_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++; if (rf_we !== 1'b0) $display("FAIL mid_post_we_%0d got %0b want 0", k, rf_we); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_fill();
        test_sec_latency();
        test_squash();
        test_collision();
        test_r0();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
